// File: rtl/pmem_responder_pkg.sv
// Package shared by the pmem responder files.
// Contents:
//   pmem_line_t       one 256-bit memory line
//   PMEM_OFFSET_BITS  byte-offset bits inside a line (ignored by the responder)
//   ST_*              responder FSM state encodings
//   sat_inc           saturating 32-bit increment used by the request counters
package pmem_responder_pkg;

  localparam int PMEM_OFFSET_BITS = 5;
  localparam int PMEM_LINE_BITS   = 256;

  typedef logic [PMEM_LINE_BITS-1:0] pmem_line_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pmem_array.sv
// Line storage for the pmem responder: 2^s_lines lines of 256 bits.
// Ports:
//   clk    clock
//   we     write enable; wdata is stored at waddr on the rising edge
//   waddr  write line index
//   wdata  write line
//   re     read enable; rdata is loaded from raddr on the rising edge
//   raddr  read line index
//   rdata  registered read line, holds its value while re is low
// The storage has no reset, so contents survive a responder reset.
module pmem_array
  import pmem_responder_pkg::*;
#(
  parameter int s_lines = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [s_lines-1:0]        waddr,
  input  logic [PMEM_LINE_BITS-1:0] wdata,
  input  logic                      re,
  input  logic [s_lines-1:0]        raddr,
  output logic [PMEM_LINE_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << s_lines;

  pmem_line_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Slave end of the 256-bit line-oriented pmem interface.
// Accepts one line request at a time, answers it LATENCY cycles after
// acceptance with a single-cycle pmem_resp pulse, flags protocol violations
// on a sticky error bit and counts completed reads and writes.
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   pmem_read     line read request, held by the initiator until pmem_resp
//   pmem_write    line write request, held by the initiator until pmem_resp
//   pmem_address  byte address, bits [4:0] ignored
//   pmem_wdata    write line
//   pmem_rdata    read line, valid in the pmem_resp cycle of a read
//   pmem_resp     completion pulse
//   pmem_err      sticky protocol-violation flag
//   read_count    completed reads, saturating
//   write_count   completed writes, saturating
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int s_lines = 8,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_err,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
);

  localparam int TAG_BITS = 32 - PMEM_OFFSET_BITS;

  // Counter preload so that BUSY lasts LATENCY-1 cycles.
  localparam int         BUSY_INIT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [7:0] BUSY_INIT   = BUSY_INIT_I[7:0];

  logic [1:0]          state;
  logic [7:0]          lat_cnt;
  logic                op_write;
  logic [1:0]          op_raw;
  logic [s_lines-1:0]  idx;
  logic [TAG_BITS-1:0] addr_tag;
  logic                have_read;

  logic                request;
  logic                accept;
  logic                enter_resp;
  logic [s_lines-1:0]  live_idx;
  logic [TAG_BITS-1:0] live_tag;
  logic                arr_we;
  logic                arr_re;
  logic [s_lines-1:0]  arr_raddr;
  logic [255:0]        arr_q;
  logic                in_flight;
  logic                violation;

  // Byte-offset bits carry no meaning for a line responder.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, pmem_address[PMEM_OFFSET_BITS-1:0]};

  assign request  = pmem_read | pmem_write;
  assign accept   = (state == ST_IDLE) && request;
  assign live_idx = pmem_address[PMEM_OFFSET_BITS +: s_lines];
  assign live_tag = pmem_address[31:PMEM_OFFSET_BITS];

  // A write is committed to the array at the acceptance edge. Gating with
  // rst_n keeps stray request inputs from touching the array while reset is
  // held, since the array itself is never cleared.
  assign arr_we = rst_n && accept && pmem_write;

  assign enter_resp = ((LATENCY == 1) && accept) ||
                      ((state == ST_BUSY) && (lat_cnt == 8'd0));

  // The array read is issued on the edge that enters RESP so the line shows
  // up on pmem_rdata in the response cycle. With LATENCY==1 that edge is the
  // acceptance edge, before the index has been latched.
  assign arr_raddr = accept ? live_idx : idx;
  assign arr_re    = rst_n && enter_resp && (accept ? !pmem_write : !op_write);

  // While a request is outstanding the initiator must hold op and line
  // address stable; anything else is a protocol violation.
  assign in_flight = (state == ST_BUSY) || (state == ST_RESP);
  assign violation = in_flight &&
                     ((live_tag != addr_tag) || ({pmem_read, pmem_write} != op_raw));

  pmem_array #(
    .s_lines(s_lines)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(live_idx),
    .wdata(pmem_wdata),
    .re   (arr_re),
    .raddr(arr_raddr),
    .rdata(arr_q)
  );

  // The array output register has no reset, so the visible read line is
  // forced to zero until the first read after reset has loaded it.
  assign pmem_rdata = have_read ? arr_q : '0;
  assign pmem_resp  = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_cnt     <= 8'd0;
      op_write    <= 1'b0;
      op_raw      <= 2'b00;
      idx         <= '0;
      addr_tag    <= '0;
      have_read   <= 1'b0;
      pmem_err    <= 1'b0;
      read_count  <= 32'd0;
      write_count <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (request) begin
            // Simultaneous read and write resolves to a write.
            op_write <= pmem_write;
            op_raw   <= {pmem_read, pmem_write};
            idx      <= live_idx;
            addr_tag <= live_tag;
            if (pmem_read && pmem_write) begin
              pmem_err <= 1'b1;
            end
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state   <= ST_BUSY;
              lat_cnt <= BUSY_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (lat_cnt == 8'd0) begin
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (op_write) begin
            write_count <= sat_inc(write_count);
          end else begin
            read_count <= sat_inc(read_count);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (violation) begin
        pmem_err <= 1'b1;
      end
      if (arr_re) begin
        have_read <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_err;
  logic [31:0]  read_count;
  logic [31:0]  write_count;

  int n_cmp;
  int n_mis;

  pmem_responder #(
    .s_lines(8),
    .LATENCY(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .pmem_err    (pmem_err),
    .read_count  (read_count),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a rising edge with the responder idle. Holds the
  // request until the edge after pmem_resp, then drops it. resp_cyc is the
  // cycle offset of the first pmem_resp (-1 if none within the budget).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, output int resp_cyc,
                         output logic [255:0] rdat);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    resp_cyc     = -1;
    rdat         = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) begin
        resp_cyc = c;
        rdat     = pmem_rdata;
      end
      @(posedge clk);
      #1;
      if (resp_cyc >= 0) break;
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    $display("txn rd=%0b wr=%0b addr=%08h resp_cyc=%0d rdata[31:0]=%08h",
             rd, wr, addr, resp_cyc, rdat[31:0]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      pmem_read    = 1'($urandom_range(0, 1));
      pmem_write   = 1'($urandom_range(0, 1));
      pmem_address = $urandom;
      pmem_wdata   = {8{$urandom}};
    end
    @(negedge clk);
    n_cmp++; if (pmem_resp !== 1'b0) begin n_mis++; $display("FAIL reset_resp got=%0b want=0", pmem_resp); end
    n_cmp++; if (pmem_rdata !== 256'd0) begin n_mis++; $display("FAIL reset_rdata got=%064h want=0", pmem_rdata); end
    n_cmp++; if (pmem_err !== 1'b0) begin n_mis++; $display("FAIL reset_err got=%0b want=0", pmem_err); end
    n_cmp++; if (read_count !== 32'd0) begin n_mis++; $display("FAIL reset_rcount got=%0d want=0", read_count); end
    n_cmp++; if (write_count !== 32'd0) begin n_mis++; $display("FAIL reset_wcount got=%0d want=0", write_count); end
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int           rc;
    logic [255:0] rd;
    run_txn(1'b0, 1'b1, 32'h0000_0020, {8{32'hDEADBEEF}}, rc, rd);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL basic_wr_latency got=%0d want=4", rc); end
    run_txn(1'b1, 1'b0, 32'h0000_0020, '0, rc, rd);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL basic_rd_latency got=%0d want=4", rc); end
    n_cmp++; if (rd !== {8{32'hDEADBEEF}}) begin n_mis++; $display("FAIL basic_rdata got=%064h want=%064h", rd, {8{32'hDEADBEEF}}); end
    @(negedge clk);
    n_cmp++; if (write_count !== 32'd1) begin n_mis++; $display("FAIL basic_wcount got=%0d want=1", write_count); end
    n_cmp++; if (read_count !== 32'd1) begin n_mis++; $display("FAIL basic_rcount got=%0d want=1", read_count); end
    n_cmp++; if (pmem_resp !== 1'b0) begin n_mis++; $display("FAIL basic_resp_pulse got=%0b want=0", pmem_resp); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int           rc;
    logic [255:0] rd;
    run_txn(1'b0, 1'b1, 32'h0000_0040, {8{32'h0BAD0040}}, rc, rd);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL b2b_wr_latency got=%0d want=4", rc); end
    run_txn(1'b1, 1'b0, 32'h0000_0040, '0, rc, rd);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL b2b_rd_latency got=%0d want=4", rc); end
    n_cmp++; if (rd !== {8{32'h0BAD0040}}) begin n_mis++; $display("FAIL b2b_rdata got=%064h want=%064h", rd, {8{32'h0BAD0040}}); end
  endtask

  task automatic test_alias;
    int           rc;
    logic [255:0] rd;
    run_txn(1'b0, 1'b1, 32'h0000_0040, {8{32'h12345678}}, rc, rd);
    run_txn(1'b1, 1'b0, 32'h0000_2045, '0, rc, rd);
    n_cmp++; if (rd !== {8{32'h12345678}}) begin n_mis++; $display("FAIL alias_rdata got=%064h want=%064h", rd, {8{32'h12345678}}); end
    // Write to another line: the read line must not change.
    run_txn(1'b0, 1'b1, 32'h0000_0100, {8{32'h55AA0100}}, rc, rd);
    @(negedge clk);
    n_cmp++; if (pmem_err !== 1'b0) begin n_mis++; $display("FAIL alias_err got=%0b want=0", pmem_err); end
    n_cmp++; if (pmem_rdata !== {8{32'h12345678}}) begin n_mis++; $display("FAIL rdata_hold got=%064h want=%064h", pmem_rdata, {8{32'h12345678}}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_protocol_err;
    int           rc;
    logic [255:0] rd;
    run_txn(1'b0, 1'b1, 32'h0000_0080, {8{32'hA5A50080}}, rc, rd);
    run_txn(1'b0, 1'b1, 32'h0000_00A0, {8{32'h000000A0}}, rc, rd);
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_0080;
    @(posedge clk);
    #1;
    pmem_address = 32'h0000_00A0;
    @(negedge clk);
    n_cmp++; if (pmem_err !== 1'b0) begin n_mis++; $display("FAIL perr_early got=%0b want=0", pmem_err); end
    rc = -1;
    rd = '0;
    for (int c = 2; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_cmp++; if (pmem_err !== 1'b1) begin n_mis++; $display("FAIL perr_set got=%0b want=1", pmem_err); end
      end
      if (pmem_resp === 1'b1) begin
        rc = c;
        rd = pmem_rdata;
      end
      @(posedge clk);
      #1;
      if (rc >= 0) break;
    end
    pmem_read = 1'b0;
    $display("txn rd=1 wr=0 addr=00000080->000000a0 resp_cyc=%0d rdata[31:0]=%08h", rc, rd[31:0]);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL perr_latency got=%0d want=4", rc); end
    n_cmp++; if (rd !== {8{32'hA5A50080}}) begin n_mis++; $display("FAIL perr_rdata got=%064h want=%064h", rd, {8{32'hA5A50080}}); end
    run_txn(1'b1, 1'b0, 32'h0000_00A0, '0, rc, rd);
    n_cmp++; if (rd !== {8{32'h000000A0}}) begin n_mis++; $display("FAIL perr_clean_rdata got=%064h want=%064h", rd, {8{32'h000000A0}}); end
    @(negedge clk);
    n_cmp++; if (pmem_err !== 1'b1) begin n_mis++; $display("FAIL perr_sticky got=%0b want=1", pmem_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_both_high;
    int           rc;
    logic [255:0] rd;
    run_txn(1'b1, 1'b1, 32'h0000_0120, {8{32'hB07B0120}}, rc, rd);
    n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL both_latency got=%0d want=4", rc); end
    run_txn(1'b1, 1'b0, 32'h0000_0120, '0, rc, rd);
    n_cmp++; if (rd !== {8{32'hB07B0120}}) begin n_mis++; $display("FAIL both_as_write got=%064h want=%064h", rd, {8{32'hB07B0120}}); end
    // Writes so far: 0x20, 0x40, 0x40, 0x100, 0x80, 0xA0, 0x120 = 7.
    @(negedge clk);
    n_cmp++; if (write_count !== 32'd7) begin n_mis++; $display("FAIL both_wcount got=%0d want=7", write_count); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    int           rc;
    logic [255:0] rd;
    int           seen;
    pmem_write   = 1'b1;
    pmem_address = 32'h0000_0060;
    pmem_wdata   = {8{32'hCAFEF00D}};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    pmem_write = 1'b0;
    seen       = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pmem_resp === 1'b1) seen++;
      @(posedge clk);
      #1;
      if (c == 0) rst_n = 1'b1;
    end
    $display("txn rd=0 wr=1 addr=00000060 aborted by reset resp_seen=%0d", seen);
    n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL abort_no_resp got=%0d want=0", seen); end
    @(negedge clk);
    n_cmp++; if (write_count !== 32'd0) begin n_mis++; $display("FAIL abort_wcount got=%0d want=0", write_count); end
    n_cmp++; if (pmem_err !== 1'b0) begin n_mis++; $display("FAIL abort_err_clear got=%0b want=0", pmem_err); end
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h0000_0060, '0, rc, rd);
    n_cmp++; if (rd !== {8{32'hCAFEF00D}}) begin n_mis++; $display("FAIL abort_committed got=%064h want=%064h", rd, {8{32'hCAFEF00D}}); end
    @(negedge clk);
    n_cmp++; if (read_count !== 32'd1) begin n_mis++; $display("FAIL abort_rcount got=%0d want=1", read_count); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_mis        = 0;
    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_alias();
    test_protocol_err();
    test_both_high();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
